// File: rtl/ql_bus_master.sv
// ql_bus_master: 68008-style byte bus-cycle initiator for the QL expansion bus.
// A one-shot req is turned into an ASL/DSL/RDWL sequence that waits for a
// DTACKL assertion, then for its negation, before reporting done.
// Optional build macro QL_BUS_TIMEOUT_EN adds an abort counter on both
// DTACKL waits; without it err is tied low and the waits are unbounded.
module ql_bus_master #(
  parameter int ADDR_W  = 20,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic              busy,
  output logic              done,
  output logic [7:0]        rdata,
  output logic              err,
  output logic [ADDR_W-1:0] a,
  output logic [7:0]        d_out,
  output logic              d_oe,
  input  logic [7:0]        d_in,
  output logic              asl,
  output logic              dsl,
  output logic              rdwl,
  input  logic              dtackl
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ASSERT, DSW, WAIT, NEGATE, RELEASE
  } state_t;

  state_t state, state_nxt;
  logic   we_r;
  logic   dtack_s1, dtack_s2;
  logic   tout_wait, tout_rel;

  assign busy = (state != IDLE);

`ifdef QL_BUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt;

  assign tout_wait = (state == WAIT)    && (cnt == CNT_W'(TIMEOUT - 1));
  assign tout_rel  = (state == RELEASE) && (cnt == CNT_W'(TIMEOUT - 1));

  // Wait-time counter: restarts on entry to each DTACKL wait state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if ((state_nxt != state) &&
                 ((state_nxt == WAIT) || (state_nxt == RELEASE))) begin
      cnt <= '0;
    end else if ((state == WAIT) || (state == RELEASE)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Error flag: cleared when a new cycle starts, set by either timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((state == IDLE) && req) begin
      err <= 1'b0;
    end else if ((tout_wait && dtack_s2) || (tout_rel && !dtack_s2)) begin
      err <= 1'b1;
    end
  end
`else
  assign tout_wait = 1'b0;
  assign tout_rel  = 1'b0;
  assign err       = 1'b0;
`endif

  // State register, DTACKL synchronizer and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dtack_s1 <= 1'b1;
      dtack_s2 <= 1'b1;
      done     <= 1'b0;
      we_r     <= 1'b0;
    end else begin
      state    <= state_nxt;
      dtack_s1 <= dtackl;
      dtack_s2 <= dtack_s1;
      done     <= (state == RELEASE) && (state_nxt == IDLE);
      if ((state == IDLE) && req) begin
        we_r <= we;
      end
    end
  end

  // Request latches and read-data capture on the DTACKL-seen edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      a     <= '0;
      d_out <= '0;
      rdata <= '0;
    end else begin
      if ((state == IDLE) && req) begin
        a     <= addr;
        d_out <= wdata;
      end
      if ((state == WAIT) && !dtack_s2 && !we_r) begin
        rdata <= d_in;
      end
    end
  end

  // Next-state and strobe decode; strobes idle negated.
  always_comb begin
    state_nxt = state;
    asl       = 1'b1;
    dsl       = 1'b1;
    rdwl      = 1'b1;
    d_oe      = 1'b0;
    case (state)
      IDLE: begin
        if (req) state_nxt = ADDR;
      end
      ADDR: begin
        rdwl      = !we_r;
        d_oe      = we_r;
        state_nxt = ASSERT;
      end
      ASSERT: begin
        asl  = 1'b0;
        rdwl = !we_r;
        d_oe = we_r;
        if (we_r) begin
          state_nxt = DSW;
        end else begin
          dsl       = 1'b0;
          state_nxt = WAIT;
        end
      end
      DSW: begin
        asl       = 1'b0;
        dsl       = 1'b0;
        rdwl      = 1'b0;
        d_oe      = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        asl  = 1'b0;
        dsl  = 1'b0;
        rdwl = !we_r;
        d_oe = we_r;
        if (!dtack_s2 || tout_wait) state_nxt = NEGATE;
      end
      NEGATE: begin
        rdwl      = !we_r;
        d_oe      = we_r;
        state_nxt = RELEASE;
      end
      RELEASE: begin
        if (dtack_s2 || tout_rel) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ql_bus_master.sv
// Bench for ql_bus_master: directed bus cycles against a delay-programmable
// responder; completions are checked by a scoreboard monitor on done.
module tb_ql_bus_master;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [19:0] addr;
  logic [7:0]  wdata;
  logic        busy, done, err;
  logic [7:0]  rdata;
  logic [19:0] a;
  logic [7:0]  d_out;
  logic        d_oe;
  logic [7:0]  d_in;
  logic        asl, dsl, rdwl, dtackl;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Responder controls
  int   delay    = 0;
  logic force_hi = 1'b0;
  logic force_lo = 1'b0;
  int   lowcnt   = 0;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         lat;
    int         req_cyc;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  ql_bus_master #(.ADDR_W(20), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .err(err), .a(a),
    .d_out(d_out), .d_oe(d_oe), .d_in(d_in), .asl(asl), .dsl(dsl),
    .rdwl(rdwl), .dtackl(dtackl)
  );

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) lowcnt <= dsl ? 0 : lowcnt + 1;

  assign dtackl = force_hi ? 1'b1 :
                  force_lo ? 1'b0 :
                  (dsl | (lowcnt < delay));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("done rdata", {24'd0, rdata}, {24'd0, e.rdata});
        check("done err", {31'd0, err}, {31'd0, e.err});
        check("done latency", cyc - e.req_cyc, e.lat);
        check("done with busy", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [19:0] ad, input logic [7:0] wd,
                       input logic push, input logic [7:0] er, input logic ee, input int lat);
    exp_t e;
    req = 1'b1; we = w; addr = ad; wdata = wd;
    if (push) begin
      e.rdata = er; e.err = ee; e.lat = lat; e.req_cyc = cyc;
      q.push_back(e);
    end
    step();
    req = 1'b0;
  endtask

  task automatic wave_check(input string nm, input logic [35:0] tbl, input int n,
                            input logic [19:0] ea, input logic w, input logic [7:0] ed);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      check($sformatf("%s c%0d strobes", nm, i), {28'd0, asl, dsl, rdwl, d_oe},
            {28'd0, tbl[4*(i-1) +: 4]});
      check($sformatf("%s c%0d addr", nm, i), {12'd0, a}, {12'd0, ea});
      if (w && i == 1) check($sformatf("%s c1 d_out", nm), {24'd0, d_out}, {24'd0, ed});
    end
    step();
  endtask

  task automatic wait_done;
    int n;
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    check("done within bound", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; d_in = 8'h00;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    check("rst asl", {31'd0, asl}, 32'd1);
    check("rst dsl", {31'd0, dsl}, 32'd1);
    check("rst rdwl", {31'd0, rdwl}, 32'd1);
    check("rst d_oe", {31'd0, d_oe}, 32'd0);
    check("rst d_out", {24'd0, d_out}, 32'd0);
    check("rst a", {12'd0, a}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst err", {31'd0, err}, 32'd0);
    check("rst rdata", {24'd0, rdata}, 32'd0);
    step();

    // Read against the reference responder
    d_in = 8'h5A;
    issue(1'b0, 20'hC0020, 8'h00, 1'b1, 8'h5A, 1'b0, 8);
    wave_check("read", {4'h0, 4'b1110, 4'b1110, 4'b1110, 4'b1110,
                        4'b0010, 4'b0010, 4'b0010, 4'b1110}, 8, 20'hC0020, 1'b0, 8'h00);
    step();

    // Write: rdata must keep the previous read value
    issue(1'b1, 20'hC0024, 8'hA5, 1'b1, 8'h5A, 1'b0, 9);
    wave_check("write", {4'b1110, 4'b1110, 4'b1110, 4'b1101, 4'b0001,
                         4'b0001, 4'b0001, 4'b0101, 4'b1101}, 9, 20'hC0024, 1'b1, 8'hA5);
    step();

    // Slow responder, req pulse while busy, back-to-back req in done cycle
    delay = 5; d_in = 8'h3C;
    issue(1'b0, 20'hC0028, 8'h00, 1'b1, 8'h3C, 1'b0, 13);
    step(); step();
    req = 1'b1; we = 1'b1; addr = 20'h12345; wdata = 8'hFF;
    step();
    req = 1'b0;
    @(negedge clk);
    check("busy req ignored addr", {12'd0, a}, {12'd0, 20'hC0028});
    check("busy req ignored rdwl", {31'd0, rdwl}, 32'd1);
    wait_done();
    delay = 0; d_in = 8'h77;
    issue(1'b0, 20'hC002C, 8'h00, 1'b1, 8'h77, 1'b0, 8);
    wait_done();
    step(); step();

    // Reset while in WAIT
    delay = 20;
    issue(1'b0, 20'hC0030, 8'h00, 1'b0, 8'h00, 1'b0, 0);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst in wait asl", {31'd0, asl}, 32'd1);
    check("rst in wait dsl", {31'd0, dsl}, 32'd1);
    check("rst in wait d_oe", {31'd0, d_oe}, 32'd0);
    check("rst in wait busy", {31'd0, busy}, 32'd0);
    check("rst in wait done", {31'd0, done}, 32'd0);
    step();
    delay = 0;
    repeat (4) step();

    // rst and req together: rst wins
    rst = 1'b1; req = 1'b1; we = 1'b0; addr = 20'hC0040;
    step();
    rst = 1'b0; req = 1'b0;
    @(negedge clk);
    check("rst+req busy", {31'd0, busy}, 32'd0);
    check("rst+req asl", {31'd0, asl}, 32'd1);
    step();
    repeat (3) step();

`ifdef QL_BUS_TIMEOUT_EN
    d_in = 8'h42;
    issue(1'b0, 20'hC0050, 8'h00, 1'b1, 8'h42, 1'b0, 8);
    wait_done();
    step();
    // DTACKL never asserted: WAIT times out, rdata untouched
    force_hi = 1'b1; d_in = 8'h99;
    issue(1'b0, 20'hC0054, 8'h00, 1'b1, 8'h42, 1'b1, 21);
    wait_done();
    step();
    force_hi = 1'b0;
    // DTACKL stuck low: RELEASE times out
    force_lo = 1'b1;
    repeat (3) step();
    d_in = 8'h66;
    issue(1'b0, 20'hC0058, 8'h00, 1'b1, 8'h66, 1'b1, 21);
    wait_done();
    step();
    force_lo = 1'b0;
    repeat (4) step();
    d_in = 8'h11;
    issue(1'b0, 20'hC005C, 8'h00, 1'b1, 8'h11, 1'b0, 8);
    wait_done();
    step();
`endif

    repeat (5) step();
    check("scoreboard drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
